// File: rtl/calc_entry_controller_if.sv
// Key-event, ALU handshake and display-facing bus of the calculator entry controller.
// The controller sits on the slave side; the keyboard/ALU/display environment is the master.
interface calc_entry_controller_if;
  logic       key_valid;
  logic [2:0] key_code;
  logic [3:0] key_digit;
  logic       alu_done;
  logic [3:0] a_tens;
  logic [3:0] a_ones;
  logic [3:0] b_tens;
  logic [3:0] b_ones;
  logic [1:0] op;
  logic       alu_start;
  logic [2:0] state;
  logic       err;

  modport master (
    output key_valid, key_code, key_digit, alu_done,
    input  a_tens, a_ones, b_tens, b_ones, op, alu_start, state, err
  );

  modport slave (
    input  key_valid, key_code, key_digit, alu_done,
    output a_tens, a_ones, b_tens, b_ones, op, alu_start, state, err
  );
endinterface

// File: rtl/calc_entry_controller.sv
// Entry sequencer for the two-digit calculator: operand A, operator, operand B,
// ALU start/done handshake with timeout, and result/error display states.
module calc_entry_controller #(
  parameter int TIMEOUT = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  calc_entry_controller_if.slave   bus
);

  // Handshake: alu_start is a one-cycle pulse in the first EXEC cycle; alu_done is a
  // one-cycle pulse honoured only in a later EXEC cycle, otherwise ignored.
  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_EXEC    = 3'd2,
    S_SHOW    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  localparam logic [2:0] K_DIGIT = 3'd0;
  localparam logic [2:0] K_ADD   = 3'd1;
  localparam logic [2:0] K_SUB   = 3'd2;
  localparam logic [2:0] K_MUL   = 3'd3;
  localparam logic [2:0] K_ENTER = 3'd4;
  localparam logic [2:0] K_BACK  = 3'd5;
  localparam logic [2:0] K_CLEAR = 3'd6;

  localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);

  state_t      st;
  logic [3:0]  a_tens, a_ones, b_tens, b_ones;
  logic [1:0]  op;
  logic [1:0]  cnt_a, cnt_b;
  logic [15:0] tcnt;
  logic        alu_start;
  logic        err;

  logic       is_digit, is_oper, is_clear;
  logic [1:0] oper_code;

  always_comb begin
    is_digit  = bus.key_valid && (bus.key_code == K_DIGIT) && (bus.key_digit <= 4'd9);
    is_oper   = bus.key_valid && ((bus.key_code == K_ADD) || (bus.key_code == K_SUB) ||
                                  (bus.key_code == K_MUL));
    is_clear  = bus.key_valid && (bus.key_code == K_CLEAR);
    oper_code = bus.key_code[1:0] - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_ENTER_A;
      a_tens    <= '0;
      a_ones    <= '0;
      b_tens    <= '0;
      b_ones    <= '0;
      op        <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      tcnt      <= '0;
      alu_start <= 1'b0;
      err       <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      if (is_clear) begin
        st     <= S_ENTER_A;
        a_tens <= '0;
        a_ones <= '0;
        b_tens <= '0;
        b_ones <= '0;
        op     <= '0;
        cnt_a  <= '0;
        cnt_b  <= '0;
        tcnt   <= '0;
        err    <= 1'b0;
      end else begin
        case (st)
          S_ENTER_A: begin
            if (is_digit && cnt_a != 2'd2) begin
              a_tens <= a_ones;
              a_ones <= bus.key_digit;
              cnt_a  <= cnt_a + 2'd1;
            end else if (is_oper) begin
              op <= oper_code;
              st <= S_ENTER_B;
            end else if (bus.key_valid && bus.key_code == K_BACK && cnt_a != 2'd0) begin
              a_ones <= a_tens;
              a_tens <= '0;
              cnt_a  <= cnt_a - 2'd1;
            end
          end
          S_ENTER_B: begin
            if (is_digit && cnt_b != 2'd2) begin
              b_tens <= b_ones;
              b_ones <= bus.key_digit;
              cnt_b  <= cnt_b + 2'd1;
            end else if (is_oper && cnt_b == 2'd0) begin
              op <= oper_code;
            end else if (bus.key_valid && bus.key_code == K_BACK) begin
              // Backspacing past an empty B reopens A with its digits and op intact.
              if (cnt_b == 2'd0) begin
                st <= S_ENTER_A;
              end else begin
                b_ones <= b_tens;
                b_tens <= '0;
                cnt_b  <= cnt_b - 2'd1;
              end
            end else if (bus.key_valid && bus.key_code == K_ENTER && cnt_b != 2'd0) begin
              st        <= S_EXEC;
              alu_start <= 1'b1;
              tcnt      <= '0;
            end
          end
          S_EXEC: begin
            // A done coinciding with the start pulse cannot belong to this operation.
            if (bus.alu_done && !alu_start) begin
              st <= S_SHOW;
            end else if (tcnt == T_LAST) begin
              st  <= S_ERROR;
              err <= 1'b1;
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end
          S_SHOW, S_ERROR: begin
            if (is_digit) begin
              st     <= S_ENTER_A;
              a_tens <= '0;
              a_ones <= bus.key_digit;
              b_tens <= '0;
              b_ones <= '0;
              op     <= '0;
              cnt_a  <= 2'd1;
              cnt_b  <= '0;
              tcnt   <= '0;
              err    <= 1'b0;
            end
          end
          default: begin
            st  <= S_ERROR;
            err <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.a_tens    = a_tens;
  assign bus.a_ones    = a_ones;
  assign bus.b_tens    = b_tens;
  assign bus.b_ones    = b_ones;
  assign bus.op        = op;
  assign bus.alu_start = alu_start;
  assign bus.state     = st;
  assign bus.err       = err;

endmodule

// File: tb/tb_calc_entry_controller.sv
// Directed bench for calc_entry_controller: key sequences with hand-computed
// operand, operator, state and handshake expectations.
module tb_calc_entry_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  calc_entry_controller_if bus ();

  calc_entry_controller #(.TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] code, input logic [3:0] digit);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    bus.key_digit = digit;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 3'd0;
    bus.key_digit = 4'd0;
  endtask

  task automatic digit(input logic [3:0] d);
    press(3'd0, d);
  endtask

  task automatic done_pulse();
    bus.alu_done = 1'b1;
    tick();
    bus.alu_done = 1'b0;
  endtask

  task automatic check_ops(input string tag, input logic [3:0] at, input logic [3:0] ao,
                           input logic [3:0] bt, input logic [3:0] bo, input logic [1:0] o);
    check({tag, "_a"}, {bus.a_tens, bus.a_ones}, {at, ao});
    check({tag, "_b"}, {bus.b_tens, bus.b_ones}, {bt, bo});
    check({tag, "_op"}, 32'(bus.op), 32'(o));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    bus.key_valid = 1'b0;
    bus.key_code  = 3'd0;
    bus.key_digit = 4'd0;
    bus.alu_done  = 1'b0;
    rst           = 1'b1;
    #12;
    check("reset_state", 32'(bus.state), 32'd0);
    check_ops("reset", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
    check("reset_start", 32'(bus.alu_start), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 42 + 17 with done five cycles after start
    digit(4'd4);
    digit(4'd2);
    press(3'd1, 4'd0);
    check("t1_state_b", 32'(bus.state), 32'd1);
    digit(4'd1);
    digit(4'd7);
    check_ops("t1_entry", 4'd4, 4'd2, 4'd1, 4'd7, 2'd0);
    press(3'd4, 4'd0);
    check("t1_exec", 32'(bus.state), 32'd2);
    check("t1_start_hi", 32'(bus.alu_start), 32'd1);
    for (int k = 1; k < 5; k++) begin
      tick();
      check($sformatf("t1_start_lo%0d", k), 32'(bus.alu_start), 32'd0);
      check($sformatf("t1_still_exec%0d", k), 32'(bus.state), 32'd2);
    end
    done_pulse();
    check("t1_show", 32'(bus.state), 32'd3);
    check_ops("t1_held", 4'd4, 4'd2, 4'd1, 4'd7, 2'd0);
    press(3'd4, 4'd0);
    check("t1_show_enter_ign", 32'(bus.state), 32'd3);

    // third digit ignored, backspace shifts, backspace with empty B returns to A
    press(3'd6, 4'd0);
    check("t2_clear", 32'(bus.state), 32'd0);
    check_ops("t2_clear", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
    press(3'd5, 4'd0);
    check_ops("t2_bs_empty", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
    digit(4'd1);
    digit(4'd2);
    digit(4'd3);
    check_ops("t2_third_ign", 4'd1, 4'd2, 4'd0, 4'd0, 2'd0);
    digit(4'd11);
    press(3'd7, 4'd0);
    check_ops("t2_bad_keys_ign", 4'd1, 4'd2, 4'd0, 4'd0, 2'd0);
    press(3'd5, 4'd0);
    check_ops("t2_bs", 4'd0, 4'd1, 4'd0, 4'd0, 2'd0);
    press(3'd2, 4'd0);
    check("t2_sub_state", 32'(bus.state), 32'd1);
    press(3'd5, 4'd0);
    check("t2_bs_back", 32'(bus.state), 32'd0);
    check_ops("t2_bs_back", 4'd0, 4'd1, 4'd0, 4'd0, 2'd1);
    digit(4'd5);
    check_ops("t2_count_kept", 4'd1, 4'd5, 4'd0, 4'd0, 2'd1);

    // operator replacement with empty B, ignored with non-empty B, then timeout
    press(3'd6, 4'd0);
    press(3'd3, 4'd0);
    check("t3_mul", 32'(bus.op), 32'd2);
    press(3'd4, 4'd0);
    check("t3_enter_empty_ign", 32'(bus.state), 32'd1);
    press(3'd1, 4'd0);
    check("t3_add", 32'(bus.op), 32'd0);
    digit(4'd5);
    press(3'd2, 4'd0);
    check_ops("t3_sub_ign", 4'd0, 4'd0, 4'd0, 4'd5, 2'd0);
    press(3'd4, 4'd0);
    check("t3_exec", 32'(bus.state), 32'd2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) check($sformatf("t3_wait%0d", k), 32'(bus.state), 32'd2);
      else       check("t3_timeout", {bus.err, 28'd0, bus.state}, {1'b1, 28'd0, 3'd4});
    end
    done_pulse();
    check("t3_late_done_ign", 32'(bus.state), 32'd4);
    press(3'd1, 4'd0);
    check("t3_err_op_ign", 32'(bus.state), 32'd4);
    digit(4'd9);
    check("t3_recover", {bus.err, 28'd0, bus.state}, 32'd0);
    check_ops("t3_recover", 4'd0, 4'd9, 4'd0, 4'd0, 2'd0);

    // done in start cycle ignored, then clear and done together: clear wins
    press(3'd1, 4'd0);
    digit(4'd1);
    press(3'd4, 4'd0);
    done_pulse();
    check("t4_done_in_start_ign", 32'(bus.state), 32'd2);
    bus.key_valid = 1'b1;
    bus.key_code  = 3'd6;
    bus.alu_done  = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 3'd0;
    bus.alu_done  = 1'b0;
    check("t4_clear_wins", 32'(bus.state), 32'd0);
    check_ops("t4_clear_wins", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
    done_pulse();
    check("t4_spurious_done", 32'(bus.state), 32'd0);
    check_ops("t4_spurious_done", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);

    // other key with done in EXEC: key ignored, done honoured
    digit(4'd6);
    press(3'd3, 4'd0);
    digit(4'd2);
    press(3'd4, 4'd0);
    tick();
    bus.key_valid = 1'b1;
    bus.key_code  = 3'd0;
    bus.key_digit = 4'd8;
    bus.alu_done  = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.alu_done  = 1'b0;
    check("t5_done_honoured", 32'(bus.state), 32'd3);
    check_ops("t5_key_ign", 4'd0, 4'd6, 4'd0, 4'd2, 2'd2);

    // asynchronous reset mid-ENTER_B
    press(3'd6, 4'd0);
    digit(4'd3);
    digit(4'd3);
    press(3'd1, 4'd0);
    digit(4'd4);
    check_ops("t6_before", 4'd3, 4'd3, 4'd0, 4'd4, 2'd0);
    rst = 1'b1;
    #1;
    check("t6_async_state", 32'(bus.state), 32'd0);
    check_ops("t6_async", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    done_pulse();
    check("t6_done_after_rst", 32'(bus.state), 32'd0);
    check("t6_err", 32'(bus.err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_entry_controller.md
# calc_entry_controller

Sequencing controller for the two-digit keyboard calculator. It consumes one-cycle decoded key events and steps through operand A entry, operator selection, operand B entry, a start/done handshake with the multi-cycle arithmetic unit, and result display. It sits between the keyboard one-pulse/decoder stage and the arithmetic unit and seven-segment display mux. It owns all operand, operator and display-mode registers.

## Interface

- TIMEOUT, default 1000: number of EXEC cycles after alu_start that the controller waits for alu_done before declaring an error (1..65535).
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle pulse; key_code/key_digit valid this cycle.
- key_code  in  3  0 digit, 1 add, 2 sub, 3 mul, 4 enter, 5 backspace, 6 clear, 7 reserved (ignored).
- key_digit  in  4  BCD digit when key_code=0; values >9 ignored.
- alu_done  in  1  one-cycle completion pulse from the arithmetic unit.
- a_tens, a_ones, b_tens, b_ones  out  4 each  BCD operand registers.
- op  out  2  00 add, 01 sub, 10 mul.
- alu_start  out  1  one-cycle start pulse.
- state  out  3  0 ENTER_A, 1 ENTER_B, 2 EXEC, 3 SHOW, 4 ERROR; drives the display mux.
- err  out  1  high in ERROR.

## Operation

- Reset: all operands 0, op=00, state=ENTER_A, alu_start=0, err=0, digit counts 0, timeout counter 0.
- Clear (code 6) in any state: same as reset, synchronously. Clear has priority over every other event, including alu_done.
- Digit entry (ENTER_A into A, ENTER_B into B): tens<=ones, ones<=digit, count+1. When count=2, further digits are ignored.
- Backspace: ones<=tens, tens<=0, count-1.
  - In ENTER_A with count 0: ignored.
  - In ENTER_B with count_b 0: return to ENTER_A; A, count_a and op are retained.
- Operator key:
  - In ENTER_A: latch op, go to ENTER_B. Operand A may be empty (00).
  - In ENTER_B with count_b=0: replaces op.
  - In ENTER_B with count_b>0: ignored.
  - In all other states: ignored.
- Enter:
  - In ENTER_B with count_b>=1: go to EXEC.
  - In all other cases: ignored.
- EXEC:
  - alu_start=1 in the first EXEC cycle only.
  - Timeout counter starts at 0 and increments every following cycle.
  - alu_done in any EXEC cycle after the start cycle: go to SHOW. A done in the start cycle is ignored.
  - Counter reaching TIMEOUT with no done: go to ERROR, err=1.
  - All keys except clear are ignored.
- SHOW / ERROR:
  - Digit key: clear A, B, both counts and op, load the digit into a_ones (count_a=1), err=0, go to ENTER_A.
  - Other keys except clear: ignored.
- alu_done outside EXEC (late or spurious): ignored.
- Operands hold their values through EXEC and SHOW. They are never altered by the ALU.

## Timing

- All outputs are registered. A key accepted at edge n is visible on outputs after edge n.
- Enter accepted at edge n gives state=EXEC and alu_start=1 after edge n. alu_start drops after edge n+1.
- alu_done sampled high at edge m (m>n+1) gives state=SHOW after edge m. Minimum start-to-SHOW is 2 cycles.
- Timeout: with no done, ERROR is entered exactly TIMEOUT cycles after the alu_start cycle.
- Same-cycle key_valid and alu_done in EXEC: clear wins (back to ENTER_A). Any other key is ignored and done is honoured.
- Asynchronous rst mid-EXEC: outputs return to reset values immediately. A pending alu_done after release is ignored (state is not EXEC).
- key_valid is assumed single-cycle. Back-to-back pulses on consecutive cycles are each processed.

## Test plan

- Keys 4,2,add,1,7,enter, then alu_done 5 cycles later → a=42, b=17, op=00, one alu_start pulse, state=3 after done.
- Digits 1,2,3 in ENTER_A, then backspace → A=12 after the third digit (ignored), A=01 after backspace. Then sub, backspace → state=0, op=01, A=01.
- mul then add with empty B → op=00. Then 5, sub → op stays 00. Enter → EXEC.
- TIMEOUT=8, no alu_done → state=4 and err=1 exactly 8 cycles after alu_start. Then digit 9 → state=0, a_ones=9, err=0.
- Clear and alu_done in the same EXEC cycle → state=0, all operands 0. A later alu_done causes no change.
- rst asserted mid-ENTER_B (A=33, B=4) → all outputs 0 and state=0 immediately, without waiting for a clock edge.
